// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_ctrl divider controller.
package clk_div_pkg;

  // Controller states: idle, running, and running with a ratio change queued
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Smallest divide ratio that yields a real period (N=0/1 are rejected)
  localparam int MIN_DIV = 2;

  // Width of the optional tick counter
  localparam int TICK_CNT_W = 16;

endpackage : clk_div_pkg

// File: rtl/clk_div_core.sv
// Phase counter plus registered tick/clk_out decode.
// The decode is computed from the next phase and the ratio that will be in
// effect next cycle, so the registered outputs line up with the phase register.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,      // divider active next cycle
  input  logic [DIV_W-1:0] div,      // ratio in effect next cycle
  input  logic             restart,  // next cycle is p=0 of a fresh period
  output logic             tick,
  output logic             clk_out
);

  logic [DIV_W-1:0] r_phase;
  logic             r_tick;
  logic             r_clk_out;
  logic [DIV_W-1:0] w_phase_next;

  // Next phase: wrap after the tick cycle, or start over when leaving IDLE
  always_comb begin
    w_phase_next = (restart || r_tick) ? '0 : r_phase + 1'b1;
  end

  // Phase register and output decode; idle forces everything low
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst || !run) begin
      r_phase   <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_phase   <= w_phase_next;
      r_tick    <= (w_phase_next == div - 1'b1);
      r_clk_out <= (w_phase_next < (div >> 1));
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;

endmodule : clk_div_core

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller.
// Owns the state machine, the valid/ready config handshake, ratio validation
// and the pending-ratio register; a new ratio only takes effect at a period
// boundary. Optional macro CLKDIV_TICK_CNT_EN adds a 16-bit tick counter port.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
`ifdef CLKDIV_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] w_cur_div_next;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] w_pend_div_next;
  logic             r_cfg_err;
  logic             w_xfer;
  logic             w_bad;
  logic             w_apply;
  logic             w_tick;
  logic             w_clk_out;

  // Handshake decode: a transfer is either applied or rejected as N<2
  always_comb begin
    w_xfer  = cfg_valid && cfg_ready;
    w_bad   = (cfg_div < DIV_W'(MIN_DIV));
    w_apply = w_xfer && !w_bad;
  end

  // Next state, next ratio and pending ratio
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_next    = r_state;
    w_cur_div_next  = r_cur_div;
    w_pend_div_next = r_pend_div;
    unique case (r_state)
      IDLE: begin
        if (w_apply) w_cur_div_next = cfg_div;
        if (en)      w_state_next   = RUN;
      end
      RUN: begin
        if (!en) begin
          // Going idle anyway, so an accepted ratio can apply directly
          w_state_next = IDLE;
          if (w_apply) w_cur_div_next = cfg_div;
        end else if (w_apply) begin
          if (w_tick) begin
            w_cur_div_next = cfg_div;
          end else begin
            w_pend_div_next = cfg_div;
            w_state_next    = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          w_state_next   = IDLE;
          w_cur_div_next = r_pend_div;
        end else if (w_tick) begin
          w_state_next   = RUN;
          w_cur_div_next = r_pend_div;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Control registers; reset drops any pending ratio
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_div  <= DIV_W'(DEF_DIV);
      r_pend_div <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_div  <= w_cur_div_next;
      r_pend_div <= w_pend_div_next;
      r_cfg_err  <= w_xfer && w_bad;
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (w_state_next != IDLE),
    .div     (w_cur_div_next),
    .restart (r_state == IDLE),
    .tick    (w_tick),
    .clk_out (w_clk_out)
  );

`ifdef CLKDIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] r_tick_cnt;

  // Free-running tick count, wraps mod 2^16, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign tick_cnt = r_tick_cnt;
`endif

  assign cfg_ready = (r_state != PEND);
  assign busy      = (r_state == PEND);
  assign cfg_err   = r_cfg_err;
  assign tick      = w_tick;
  assign clk_out   = w_clk_out;
  assign cur_div   = r_cur_div;

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (DIV_W=8, DEF_DIV=3).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             clk_out;
  logic             busy;
  logic [DIV_W-1:0] cur_div;
`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0]      tick_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_ctrl #(
    .DIV_W  (DIV_W),
    .DEF_DIV(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_div  (cfg_div),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .clk_out  (clk_out),
    .busy     (busy),
    .cur_div  (cur_div)
`ifdef CLKDIV_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus helper: drop to IDLE, load ratio d, raise en again.
  // Returns on a falling edge; the next falling edge shows p=0.
  task automatic go_idle_set(input logic [DIV_W-1:0] d);
    en = 1'b0;
    @(negedge clk);
    cfg_div   = d;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    en        = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tick, clk_out, cfg_err, busy, cfg_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00001", {tick, clk_out, cfg_err, busy, cfg_ready});
    end
    n_checks++;
    if (cur_div !== 8'd3) begin
      n_fail++;
      $display("FAIL reset_cur_div: got %0d expected 3", cur_div);
    end
  endtask

  task automatic test_default_div();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if ({clk_out, tick, cur_div} !== {(i % 3) == 0, (i % 3) == 2, 8'd3}) begin
        n_fail++;
        $display("FAIL def_div3 cyc%0d: got clk_out=%b tick=%b cur_div=%0d expected %b %b 3",
                 i, clk_out, tick, cur_div, (i % 3) == 0, (i % 3) == 2);
      end
    end
  endtask

  task automatic test_idle_cfg();
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tick, clk_out, cfg_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL idle_outputs: got %b expected 001", {tick, clk_out, cfg_ready});
    end
    cfg_div = 8'd4; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++;
    if (cur_div !== 8'd4) begin
      n_fail++;
      $display("FAIL idle_cfg_cur_div: got %0d expected 4", cur_div);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({clk_out, tick} !== {(i % 4) < 2, (i % 4) == 3}) begin
        n_fail++;
        $display("FAIL div4 cyc%0d: got clk_out=%b tick=%b expected %b %b",
                 i, clk_out, tick, (i % 4) < 2, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_pend_change();
    go_idle_set(8'd5);
    @(negedge clk);  // p=0
    @(negedge clk);  // p=1
    n_checks++;
    if ({cfg_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_pre_ready: got ready=%b busy=%b expected 1 0", cfg_ready, busy);
    end
    cfg_div = 8'd2; cfg_valid = 1'b1;
    for (int p = 2; p <= 4; p++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if ({busy, cfg_ready, tick, cur_div} !== {1'b1, 1'b0, p == 4, 8'd5}) begin
        n_fail++;
        $display("FAIL pend_wait p%0d: got busy=%b ready=%b tick=%b cur_div=%0d expected 1 0 %b 5",
                 p, busy, cfg_ready, tick, cur_div, p == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, cfg_ready, clk_out, tick, cur_div} !== {1'b0, 1'b1, (i % 2) == 0, (i % 2) == 1, 8'd2}) begin
        n_fail++;
        $display("FAIL pend_applied cyc%0d: got busy=%b ready=%b clk_out=%b tick=%b cur_div=%0d expected 0 1 %b %b 2",
                 i, busy, cfg_ready, clk_out, tick, cur_div, (i % 2) == 0, (i % 2) == 1);
      end
    end
  endtask

  task automatic test_tick_cycle_change();
    go_idle_set(8'd4);
    repeat (4) @(negedge clk);  // p=3
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tickcyc_tick: got %b expected 1", tick);
    end
    cfg_div = 8'd6; cfg_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if ({busy, clk_out, tick, cur_div} !== {1'b0, (i % 6) < 3, (i % 6) == 5, 8'd6}) begin
        n_fail++;
        $display("FAIL tickcyc_div6 cyc%0d: got busy=%b clk_out=%b tick=%b cur_div=%0d expected 0 %b %b 6",
                 i, busy, clk_out, tick, cur_div, (i % 6) < 3, (i % 6) == 5);
      end
    end
  endtask

  task automatic test_reject();
    int cnt;
    logic [DIV_W-1:0] bad_vals [2];
    bad_vals[0] = 8'd1;
    bad_vals[1] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      cfg_div = bad_vals[k]; cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_checks++;
      if ({cfg_err, busy, cur_div} !== {1'b1, 1'b0, 8'd6}) begin
        n_fail++;
        $display("FAIL reject_n%0d: got err=%b busy=%b cur_div=%0d expected 1 0 6",
                 bad_vals[k], cfg_err, busy, cur_div);
      end
      @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_pulse_n%0d: got err=%b expected 0", bad_vals[k], cfg_err);
      end
    end
    // Period still 6: find a tick, then measure distance to the next
    cnt = 0;
    while (tick !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_tick_timeout: got tick=%b expected 1", tick);
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tick !== 1'b1 && cnt < 20);
    n_checks++;
    if (cnt != 6) begin
      n_fail++;
      $display("FAIL reject_period: got %0d expected 6", cnt);
    end
  endtask

  task automatic test_max_div();
    go_idle_set(8'd255);
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      n_checks++;
      if ({clk_out, tick} !== {(i % 255) < 127, (i % 255) == 254}) begin
        n_fail++;
        $display("FAIL div255 cyc%0d: got clk_out=%b tick=%b expected %b %b",
                 i, clk_out, tick, (i % 255) < 127, (i % 255) == 254);
      end
    end
  endtask

  task automatic test_en_drop_pend();
    go_idle_set(8'd7);
    repeat (2) @(negedge clk);  // p=1
    cfg_div = 8'd3; cfg_valid = 1'b1;
    @(negedge clk);             // p=2, pending
    cfg_valid = 1'b0;
    n_checks++;
    if ({busy, cur_div} !== {1'b1, 8'd7}) begin
      n_fail++;
      $display("FAIL endrop_pending: got busy=%b cur_div=%0d expected 1 7", busy, cur_div);
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, cfg_ready, tick, clk_out, cur_div} !== {4'b0100, 8'd3}) begin
      n_fail++;
      $display("FAIL endrop_idle: got busy=%b ready=%b tick=%b clk_out=%b cur_div=%0d expected 0 1 0 0 3",
               busy, cfg_ready, tick, clk_out, cur_div);
    end
  endtask

  task automatic test_reset_mid_pend();
    go_idle_set(8'd7);
    repeat (2) @(negedge clk);  // p=1
    cfg_div = 8'd5; cfg_valid = 1'b1;
    @(negedge clk);             // p=2, pending 5
    cfg_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstpend_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tick, clk_out, cfg_err, busy, cfg_ready, cur_div} !== {5'b00001, 8'd3}) begin
      n_fail++;
      $display("FAIL rstpend_values: got %b cur_div=%0d expected 00001 3",
               {tick, clk_out, cfg_err, busy, cfg_ready}, cur_div);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, clk_out, tick, cur_div} !== {1'b0, (i % 3) == 0, (i % 3) == 2, 8'd3}) begin
        n_fail++;
        $display("FAIL rstpend_dropped cyc%0d: got busy=%b clk_out=%b tick=%b cur_div=%0d expected 0 %b %b 3",
                 i, busy, clk_out, tick, cur_div, (i % 3) == 0, (i % 3) == 2);
      end
    end
  endtask

`ifdef CLKDIV_TICK_CNT_EN
  task automatic test_tick_cnt();
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    repeat (30) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tick_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL tick_cnt_ten: got %0d expected 10", tick_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (tick_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL tick_cnt_clear: got %0d expected 0", tick_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_div();
    test_idle_cfg();
    test_pend_change();
    test_tick_cycle_change();
    test_reject();
    test_max_div();
    test_en_drop_pend();
    test_reset_mid_pend();
`ifdef CLKDIV_TICK_CNT_EN
    test_tick_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clk_div_ctrl
